// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// One access in flight at a time; every access ends with ack (optionally err) to its requester.
module mem_arbiter #(
  parameter int AWIDTH  = 5,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              ma_clk,
  input  logic              ma_rst,
  input  logic              r0_i_req,
  input  logic              r0_i_we,
  input  logic [AWIDTH-1:0] r0_i_addr,
  input  logic [DWIDTH-1:0] r0_i_data,
  input  logic [3:0]        r0_i_be,
  output logic [DWIDTH-1:0] r0_o_data,
  output logic              r0_o_ack,
  output logic              r0_o_err,
  input  logic              r1_i_req,
  input  logic              r1_i_we,
  input  logic [AWIDTH-1:0] r1_i_addr,
  input  logic [DWIDTH-1:0] r1_i_data,
  input  logic [3:0]        r1_i_be,
  output logic [DWIDTH-1:0] r1_o_data,
  output logic              r1_o_ack,
  output logic              r1_o_err,
  output logic              ma_o_cyc,
  output logic              ma_o_stb,
  output logic              ma_o_we,
  output logic [AWIDTH-1:0] ma_o_load_addr,
  output logic [AWIDTH-1:0] ma_o_store_addr,
  output logic [DWIDTH-1:0] ma_o_data,
  output logic [3:0]        ma_o_be,
  input  logic [DWIDTH-1:0] ma_i_read_data,
  input  logic              ma_i_ack,
  output logic [1:0]        dbg_state
);

  // Handshake: rN_i_req is a level held until the single-cycle rN_o_ack; fields are
  // captured at grant, so the requester may change them freely afterwards.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q;
  logic              last_q;
  logic [AWIDTH-1:0] addr_q;
  logic [CW-1:0]     cnt_q;
  logic              sel;
  logic              grant;
  logic              done_ok;
  logic              done_abort;
  logic              finish;
  logic [DWIDTH-1:0] resp_data;

  assign dbg_state       = state_q;
  assign ma_o_load_addr  = addr_q;
  assign ma_o_store_addr = addr_q;
  assign finish          = done_ok | done_abort;
  assign resp_data       = (done_abort || ma_o_we) ? '0 : ma_i_read_data;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    sel        = 1'b0;
    // On a tie the requester that did not win last time is chosen.
    if (r0_i_req && r1_i_req) sel = ~last_q;
    else if (r1_i_req)        sel = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (r0_i_req || r1_i_req) begin
          state_d = ST_ISSUE;
          grant   = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ma_i_ack) begin
          state_d = ST_DONE;
          done_ok = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = ST_DONE;
          done_abort = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ma_clk or negedge ma_rst) begin
    if (!ma_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge ma_clk or negedge ma_rst) begin
    if (!ma_rst) begin
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      cnt_q     <= '0;
      ma_o_cyc  <= 1'b0;
      ma_o_stb  <= 1'b0;
      ma_o_we   <= 1'b0;
      ma_o_data <= '0;
      ma_o_be   <= '0;
      r0_o_ack  <= 1'b0;
      r0_o_err  <= 1'b0;
      r0_o_data <= '0;
      r1_o_ack  <= 1'b0;
      r1_o_err  <= 1'b0;
      r1_o_data <= '0;
    end else begin
      ma_o_cyc <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      ma_o_stb <= (state_d == ST_ISSUE);
      r0_o_ack <= finish && !gnt_q;
      r0_o_err <= done_abort && !gnt_q;
      r1_o_ack <= finish && gnt_q;
      r1_o_err <= done_abort && gnt_q;
      if (finish && !gnt_q) r0_o_data <= resp_data;
      if (finish && gnt_q)  r1_o_data <= resp_data;
      if (grant) begin
        gnt_q     <= sel;
        last_q    <= sel;
        ma_o_we   <= sel ? r1_i_we   : r0_i_we;
        addr_q    <= sel ? r1_i_addr : r0_i_addr;
        ma_o_data <= sel ? r1_i_data : r0_i_data;
        ma_o_be   <= sel ? r1_i_be   : r0_i_be;
        cnt_q     <= '0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand sequences for contention, timeout and reset during an access.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [4:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic [3:0]  r0_be, r1_be;
  logic [31:0] r0_o_data, r1_o_data;
  logic        r0_o_ack, r0_o_err, r1_o_ack, r1_o_err;
  logic        ma_o_cyc, ma_o_stb, ma_o_we;
  logic [4:0]  ma_o_load_addr, ma_o_store_addr;
  logic [31:0] ma_o_data;
  logic [3:0]  ma_o_be;
  logic [31:0] ma_i_read_data;
  logic        ma_i_ack;
  logic [1:0]  dbg_state;

  logic [31:0] mem [32];
  bit          mem_loaded = 1'b0;
  bit          mem_en;
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [31:0] held [2];

  typedef struct {
    int          who;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [8];

  mem_arbiter #(.AWIDTH(5), .DWIDTH(32), .TIMEOUT(15)) dut (
    .ma_clk(clk), .ma_rst(rst),
    .r0_i_req(r0_req), .r0_i_we(r0_we), .r0_i_addr(r0_addr), .r0_i_data(r0_wdata), .r0_i_be(r0_be),
    .r0_o_data(r0_o_data), .r0_o_ack(r0_o_ack), .r0_o_err(r0_o_err),
    .r1_i_req(r1_req), .r1_i_we(r1_we), .r1_i_addr(r1_addr), .r1_i_data(r1_wdata), .r1_i_be(r1_be),
    .r1_o_data(r1_o_data), .r1_o_ack(r1_o_ack), .r1_o_err(r1_o_err),
    .ma_o_cyc(ma_o_cyc), .ma_o_stb(ma_o_stb), .ma_o_we(ma_o_we),
    .ma_o_load_addr(ma_o_load_addr), .ma_o_store_addr(ma_o_store_addr),
    .ma_o_data(ma_o_data), .ma_o_be(ma_o_be),
    .ma_i_read_data(ma_i_read_data), .ma_i_ack(ma_i_ack),
    .dbg_state(dbg_state)
  );

  // Clock and memory model: one-cycle registered ack, byte-lane writes.
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 3) return 32'hDEADBEEF;
    if (i == 7) return 32'h11223344;
    if (i == 0) return 32'hA5A50000;
    return {b, b, b, b};
  endfunction

  always @(posedge clk) begin
    ma_i_ack <= 1'b0;
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_loaded     <= 1'b1;
      ma_i_read_data <= '0;
    end else if (ma_o_cyc && ma_o_stb && mem_en) begin
      ma_i_ack <= 1'b1;
      if (ma_o_we) begin
        for (int b = 0; b < 4; b++)
          if (ma_o_be[b]) mem[ma_o_store_addr][8*b +: 8] <= ma_o_data[8*b +: 8];
      end else begin
        ma_i_read_data <= mem[ma_o_load_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input int n, input bit on, input bit we, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (n == 0) begin
      r0_req = on; r0_we = we; r0_addr = a; r0_wdata = d; r0_be = be;
    end else begin
      r1_req = on; r1_we = we; r1_addr = a; r1_wdata = d; r1_be = be;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    held[0] = '0;
    held[1] = '0;
    @(negedge clk);
  endtask

  // Waits (bounded) for an ack; reports which requester, stb-to-ack distance and stb count.
  task automatic wait_ack(input bit scramble, output int who, output int lat, output int stbs,
                          output logic [4:0] stb_addr, output bit stb_we, output bit ok);
    int stb_at;
    who = -1; lat = -1; stbs = 0; stb_addr = '0; stb_we = 1'b0; ok = 1'b0; stb_at = 0;
    for (int n = 1; n <= 60 && !ok; n++) begin
      @(negedge clk);
      if (ma_o_stb) begin
        stbs++;
        stb_at   = n;
        stb_addr = ma_o_load_addr;
        stb_we   = ma_o_we;
        if (scramble) begin
          r0_addr = ~r0_addr; r0_wdata = ~r0_wdata;
          r1_addr = ~r1_addr; r1_wdata = ~r1_wdata;
        end
      end
      if (r0_o_ack || r1_o_ack) begin
        ok  = 1'b1;
        who = (r0_o_ack && r1_o_ack) ? 2 : (r1_o_ack ? 1 : 0);
        lat = n - stb_at;
      end
    end
  endtask

  initial begin
    int          who, lat, stbs, other;
    logic [4:0]  sa;
    bit          swe, ok, seen, stray;
    vec_t        v;

    vecs[0] = '{0, 1'b0, 5'd3,  32'h0,        4'h0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1, 1'b1, 5'd7,  32'h000000AB, 4'h1, 32'h0,        32'h112233AB};
    vecs[2] = '{1, 1'b0, 5'd7,  32'h0,        4'h0, 32'h112233AB, 32'h112233AB};
    vecs[3] = '{0, 1'b1, 5'd7,  32'hCCDD0000, 4'hC, 32'h0,        32'hCCDD33AB};
    vecs[4] = '{0, 1'b0, 5'd7,  32'h0,        4'h0, 32'hCCDD33AB, 32'hCCDD33AB};
    vecs[5] = '{1, 1'b1, 5'd31, 32'hFFFFFFFF, 4'hF, 32'h0,        32'hFFFFFFFF};
    vecs[6] = '{1, 1'b0, 5'd31, 32'h0,        4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[7] = '{0, 1'b0, 5'd0,  32'h0,        4'h0, 32'hA5A50000, 32'hA5A50000};

    rst = 1'b0;
    mem_en = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    held[0] = '0;
    held[1] = '0;
    repeat (2) @(negedge clk);

    chk("rst_cyc", ma_o_cyc, 0);
    chk("rst_stb", ma_o_stb, 0);
    chk("rst_we", ma_o_we, 0);
    chk("rst_addr", ma_o_load_addr, 0);
    chk("rst_r0_ack", r0_o_ack, 0);
    chk("rst_r1_ack", r1_o_ack, 0);
    chk("rst_r0_err", r0_o_err, 0);
    chk("rst_r1_err", r1_o_err, 0);
    chk("rst_r0_data", r0_o_data, 0);
    chk("rst_r1_data", r1_o_data, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_req", dbg_state, 0);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      other = 1 - v.who;
      set_req(v.who, 1'b1, v.we, v.addr, v.wdata, v.be);
      wait_ack(1'b1, who, lat, stbs, sa, swe, ok);
      chk($sformatf("v%0d_ack_seen", i), 32'(ok), 1);
      chk($sformatf("v%0d_who", i), who, v.who);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_stb_count", i), stbs, 1);
      chk($sformatf("v%0d_stb_addr", i), sa, v.addr);
      chk($sformatf("v%0d_stb_we", i), 32'(swe), 32'(v.we));
      chk($sformatf("v%0d_data", i), v.who == 0 ? r0_o_data : r1_o_data, v.exp_data);
      chk($sformatf("v%0d_other_hold", i), other == 0 ? r0_o_data : r1_o_data, held[other]);
      chk($sformatf("v%0d_err", i), 32'(r0_o_err | r1_o_err), 0);
      chk($sformatf("v%0d_cyc_low", i), ma_o_cyc, 0);
      chk($sformatf("v%0d_mem", i), mem[v.addr], v.exp_mem);
      held[v.who] = v.exp_data;
      set_req(v.who, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk($sformatf("v%0d_ack_pulse", i), 32'(r0_o_ack | r1_o_ack), 0);
    end

    // Contention: both held high from reset; r0 wins the first tie, then alternation.
    do_reset();
    set_req(0, 1'b1, 1'b0, 5'd3, '0, '0);
    set_req(1, 1'b1, 1'b0, 5'd7, '0, '0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, who, lat, stbs, sa, swe, ok);
      chk($sformatf("rr%0d_ack_seen", i), 32'(ok), 1);
      chk($sformatf("rr%0d_who", i), who, i % 2);
      chk($sformatf("rr%0d_stb_count", i), stbs, 1);
      chk($sformatf("rr%0d_latency", i), lat, 2);
      chk($sformatf("rr%0d_cyc_low", i), ma_o_cyc, 0);
      chk($sformatf("rr%0d_data", i), (i % 2) == 0 ? r0_o_data : r1_o_data,
          (i % 2) == 0 ? 32'hDEADBEEF : 32'hCCDD33AB);
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);

    // Timeout: memory silent, abort after 15 WAIT cycles with err and zero data.
    mem_en = 1'b0;
    set_req(0, 1'b1, 1'b0, 5'd5, '0, '0);
    wait_ack(1'b0, who, lat, stbs, sa, swe, ok);
    chk("to_ack_seen", 32'(ok), 1);
    chk("to_who", who, 0);
    chk("to_latency", lat, 16);
    chk("to_r0_err", r0_o_err, 1);
    chk("to_r1_err", r1_o_err, 0);
    chk("to_r0_data", r0_o_data, 0);
    chk("to_cyc_low", ma_o_cyc, 0);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    mem_en = 1'b1;
    @(negedge clk);
    chk("to_ack_pulse", r0_o_ack, 0);
    chk("to_err_pulse", r0_o_err, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT: bus drops at once, no completion reaches anyone.
    mem_en = 1'b0;
    set_req(1, 1'b1, 1'b0, 5'd7, '0, '0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ma_o_cyc && !ma_o_stb) seen = 1'b1;
    end
    chk("mr_reached_wait", 32'(seen), 1);
    repeat (3) @(negedge clk);
    chk("mr_state_wait", dbg_state, 2);
    chk("mr_cyc_before", ma_o_cyc, 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_cyc_async", ma_o_cyc, 0);
    chk("mr_stb_async", ma_o_stb, 0);
    chk("mr_state_async", dbg_state, 0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (r0_o_ack || r1_o_ack || r0_o_err || r1_o_err) stray = 1'b1;
    end
    chk("mr_no_ack", 32'(stray), 0);
    mem_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 5'd3, '0, '0);
    set_req(1, 1'b1, 1'b0, 5'd7, '0, '0);
    wait_ack(1'b0, who, lat, stbs, sa, swe, ok);
    chk("mr_after_ack_seen", 32'(ok), 1);
    chk("mr_after_who", who, 0);
    chk("mr_after_data", r0_o_data, 32'hDEADBEEF);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
